// File: rtl/bnn_pkg.sv
// Shared BNN definitions: top-level state encodings and image geometry.
package bnn_pkg;

    localparam int NUM_PIXELS = 784;
    localparam int IMG_DIM    = 28;

    typedef enum logic [2:0] {
        s_IDLE    = 3'b000,
        s_LOAD    = 3'b001,
        s_LAYER_1 = 3'b010,
        s_LAYER_2 = 3'b011,
        s_LAYER_3 = 3'b100
    } state_t;

endpackage

// File: rtl/image_loader.sv
// Assembles the 784-pixel input frame from a valid/ready byte stream during s_LOAD.
// One byte per cycle; load_done rises the cycle after the last byte; ready only in L_RECV while in s_LOAD.
module image_loader
    import bnn_pkg::*;
#(
    parameter int BYTE_W = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [2:0]            state,
    input  logic [BYTE_W-1:0]     pixel_in,
    input  logic                  pixel_valid,
    output logic                  pixel_ready,
    output logic [NUM_PIXELS-1:0] image_out,
    output logic                  load_done,
    output logic                  load_abort,
    output logic [9:0]            ones_count
);

    localparam int NUM_BYTES = NUM_PIXELS / BYTE_W;
    localparam int IDX_W     = $clog2(NUM_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        L_IDLE,
        L_RECV,
        L_FULL
    } lstate_t;

    lstate_t               lstate_q;
    state_t                prev_state_q;
    logic [IDX_W-1:0]      byte_idx_q;
    logic [NUM_PIXELS-1:0] image_q;
    logic                  load_done_q;
    logic                  load_abort_q;
    logic [9:0]            ones_count_q;
    logic [9:0]            ones_count_d;
    logic [9:0]            byte_ones;
    logic                  load_entry;
    logic                  in_load;

    assign in_load     = (state == s_LOAD);
    assign load_entry  = in_load && (prev_state_q != s_LOAD);
    // Ready drops the same cycle state leaves s_LOAD, so an abort never races a transfer.
    assign pixel_ready = (lstate_q == L_RECV) && in_load;

    always_comb begin
        byte_ones = '0;
        for (int i = 0; i < BYTE_W; i++) begin
            byte_ones = byte_ones + 10'(pixel_in[i]);
        end
        ones_count_d = ones_count_q + byte_ones;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lstate_q     <= L_IDLE;
            prev_state_q <= s_IDLE;
            byte_idx_q   <= '0;
            image_q      <= '0;
            load_done_q  <= 1'b0;
            load_abort_q <= 1'b0;
            ones_count_q <= '0;
        end else begin
            prev_state_q <= state_t'(state);
            load_abort_q <= 1'b0;
            case (lstate_q)
                L_IDLE, L_FULL: begin
                    if (load_entry) begin
                        lstate_q     <= L_RECV;
                        byte_idx_q   <= '0;
                        ones_count_q <= '0;
                        load_done_q  <= 1'b0;
                    end
                end
                L_RECV: begin
                    if (!in_load) begin
                        lstate_q     <= L_IDLE;
                        byte_idx_q   <= '0;
                        load_done_q  <= 1'b0;
                        load_abort_q <= 1'b1;
                    end else if (pixel_valid) begin
                        image_q[byte_idx_q*BYTE_W +: BYTE_W] <= pixel_in;
                        ones_count_q <= ones_count_d;
                        if (byte_idx_q == LAST_IDX) begin
                            lstate_q    <= L_FULL;
                            load_done_q <= 1'b1;
                        end else begin
                            byte_idx_q <= byte_idx_q + 1'b1;
                        end
                    end
                end
                default: lstate_q <= L_IDLE;
            endcase
        end
    end

    assign image_out  = image_q;
    assign load_done  = load_done_q;
    assign load_abort = load_abort_q;
    assign ones_count = ones_count_q;

endmodule

// File: tb/tb_image_loader.sv
// Self-checking bench for image_loader: byte scoreboard plus a shadow image model.
module tb_image_loader;
    import bnn_pkg::*;

    localparam int NB = 98;

    logic         clock = 1'b0;
    logic         reset;
    logic [2:0]   state;
    logic [7:0]   pixel_in;
    logic         pixel_valid;
    logic         pixel_ready;
    logic [783:0] image_out;
    logic         load_done;
    logic         load_abort;
    logic [9:0]   ones_count;

    int total = 0;
    int bad   = 0;

    logic [783:0] img_m = '0;
    int           ones_m = 0;
    logic [7:0]   sb_q[$];

    image_loader dut (
        .clock      (clock),
        .reset      (reset),
        .state      (state),
        .pixel_in   (pixel_in),
        .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready),
        .image_out  (image_out),
        .load_done  (load_done),
        .load_abort (load_abort),
        .ones_count (ones_count)
    );

    always #5 clock = ~clock;

    // Every task starts and ends just after a falling edge; inputs change there, outputs are sampled there.
    task automatic send_frame(input int mode);
        int cyc = 0, sent = 0, rdy_cnt = 0, drops = 0, early = 0;
        int exp_rdy;
        logic [7:0] b;
        state = s_LOAD;
        pixel_valid = 1'b0;
        ones_m = 0;
        sb_q.delete();
        while (sent < NB && cyc < 1000) begin
            @(negedge clock);
            cyc++;
            pixel_valid = 1'b0;
            if (load_done !== 1'b0) early++;
            if (pixel_ready === 1'b1) rdy_cnt++;
            else drops++;
            if (pixel_ready === 1'b1 && (mode != 1 || (cyc % 2 == 0))) begin
                if (mode == 0)      b = 8'hFF;
                else if (mode == 1) b = sent[7:0];
                else                b = 8'($urandom_range(255));
                pixel_in = b;
                pixel_valid = 1'b1;
                sb_q.push_back(b);
                ones_m += $countones(b);
                sent++;
            end
        end
        total++;
        if (sent != NB) begin
            bad++;
            $display("FAIL frame_budget mode=%0d: accepted %0d bytes, need %0d", mode, sent, NB);
        end
        @(negedge clock);
        pixel_valid = 1'b0;
        exp_rdy = (mode == 1) ? 2 * NB : NB;
        total++;
        if (load_done !== 1'b1) begin
            bad++;
            $display("FAIL done_after_last mode=%0d: load_done=%b need 1", mode, load_done);
        end
        total++;
        if (pixel_ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_when_full mode=%0d: pixel_ready=%b need 0", mode, pixel_ready);
        end
        total++;
        if (rdy_cnt != exp_rdy || drops != 0 || early != 0) begin
            bad++;
            $display("FAIL ready_window mode=%0d: ready cycles=%0d drops=%0d early_done=%0d need %0d/0/0",
                     mode, rdy_cnt, drops, early, exp_rdy);
        end
        total++;
        if (ones_count !== 10'(ones_m)) begin
            bad++;
            $display("FAIL ones_count mode=%0d: got %0d need %0d", mode, ones_count, ones_m);
        end
        for (int k = 0; k < NB && sb_q.size() > 0; k++) begin
            b = sb_q.pop_front();
            img_m[k*8 +: 8] = b;
            total++;
            if (image_out[k*8 +: 8] !== b) begin
                bad++;
                $display("FAIL image_byte%0d mode=%0d: got %h need %h", k, mode, image_out[k*8 +: 8], b);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        state = s_IDLE;
        pixel_in = '0;
        pixel_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        total++;
        if (image_out !== '0 || load_done !== 1'b0 || load_abort !== 1'b0 ||
            ones_count !== '0 || pixel_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: img_zero=%b done=%b abort=%b ones=%0d ready=%b need 1/0/0/0/0",
                     image_out == '0, load_done, load_abort, ones_count, pixel_ready);
        end
    endtask

    task automatic test_all_ones();
        send_frame(0);
        total++;
        if (image_out !== {784{1'b1}}) begin
            bad++;
            $display("FAIL all_ones_image: image_out not all ones");
        end
    endtask

    task automatic test_hold_load();
        for (int i = 0; i < 4; i++) begin
            pixel_valid = 1'b1;
            pixel_in = 8'($urandom_range(255));
            @(negedge clock);
            total++;
            if (pixel_ready !== 1'b0 || image_out !== img_m || load_done !== 1'b1) begin
                bad++;
                $display("FAIL hold_load_no_reload cyc%0d: ready=%b done=%b img_ok=%b need 0/1/1",
                         i, pixel_ready, load_done, image_out === img_m);
            end
        end
        pixel_valid = 1'b0;
        state = s_IDLE;
        @(negedge clock);
    endtask

    task automatic test_toggle();
        send_frame(1);
        state = s_IDLE;
        @(negedge clock);
    endtask

    task automatic test_abort();
        int sent = 0;
        state = s_LOAD;
        while (sent < 40) begin
            @(negedge clock);
            pixel_valid = 1'b0;
            if (pixel_ready === 1'b1) begin
                pixel_in = 8'h01;
                pixel_valid = 1'b1;
                sent++;
            end
        end
        @(negedge clock);
        state = s_LAYER_1;
        pixel_in = 8'hFF;
        pixel_valid = 1'b1;
        @(negedge clock);
        pixel_valid = 1'b0;
        total++;
        if (load_abort !== 1'b1 || load_done !== 1'b0 || pixel_ready !== 1'b0) begin
            bad++;
            $display("FAIL abort_pulse: abort=%b done=%b ready=%b need 1/0/0", load_abort, load_done, pixel_ready);
        end
        total++;
        if (ones_count !== 10'd40 || image_out[40*8 +: 8] !== img_m[40*8 +: 8]) begin
            bad++;
            $display("FAIL abort_blocks_transfer: ones=%0d byte40=%h need 40/%h",
                     ones_count, image_out[40*8 +: 8], img_m[40*8 +: 8]);
        end
        @(negedge clock);
        total++;
        if (load_abort !== 1'b0 || load_done !== 1'b0) begin
            bad++;
            $display("FAIL abort_one_cycle: abort=%b done=%b need 0/0", load_abort, load_done);
        end
        state = s_IDLE;
        @(negedge clock);
        send_frame(2);
    endtask

    task automatic test_freeze();
        for (int s = 0; s < 3; s++) begin
            state = (s == 0) ? s_LAYER_1 : (s == 1) ? s_LAYER_2 : s_LAYER_3;
            for (int i = 0; i < 3; i++) begin
                pixel_valid = 1'b1;
                pixel_in = 8'($urandom_range(255));
                @(negedge clock);
                total++;
                if (pixel_ready !== 1'b0 || load_done !== 1'b1 || image_out !== img_m) begin
                    bad++;
                    $display("FAIL freeze_layer%0d: ready=%b done=%b img_ok=%b need 0/1/1",
                             s + 1, pixel_ready, load_done, image_out === img_m);
                end
            end
        end
        pixel_valid = 1'b0;
        state = s_IDLE;
        @(negedge clock);
    endtask

    task automatic test_reentry();
        logic [7:0] b;
        state = s_LOAD;
        @(negedge clock);
        total++;
        if (load_done !== 1'b0 || pixel_ready !== 1'b1) begin
            bad++;
            $display("FAIL reentry_done_drop: done=%b ready=%b need 0/1", load_done, pixel_ready);
        end
        b = ~img_m[7:0];
        pixel_in = b;
        pixel_valid = 1'b1;
        @(negedge clock);
        pixel_valid = 1'b0;
        total++;
        if (image_out[7:0] !== b || image_out[783:8] !== img_m[783:8] || ones_count !== 10'($countones(b))) begin
            bad++;
            $display("FAIL reentry_first_byte: byte0=%h ones=%0d rest_ok=%b need %h/%0d/1",
                     image_out[7:0], ones_count, image_out[783:8] === img_m[783:8], b, $countones(b));
        end
        state = s_IDLE;
        @(negedge clock);
    endtask

    task automatic test_reset_mid();
        int sent = 0;
        state = s_LOAD;
        while (sent < 51) begin
            @(negedge clock);
            pixel_valid = 1'b0;
            if (pixel_ready === 1'b1) begin
                pixel_in = 8'($urandom_range(255));
                pixel_valid = 1'b1;
                sent++;
            end
        end
        @(negedge clock);
        pixel_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        total++;
        if (image_out !== '0 || load_done !== 1'b0 || pixel_ready !== 1'b0 ||
            ones_count !== '0 || load_abort !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_frame: img_zero=%b done=%b ready=%b ones=%0d abort=%b need 1/0/0/0/0",
                     image_out == '0, load_done, pixel_ready, ones_count, load_abort);
        end
        state = s_IDLE;
        for (int i = 0; i < 3; i++) begin
            pixel_valid = 1'b1;
            pixel_in = 8'hFF;
            @(negedge clock);
            total++;
            if (pixel_ready !== 1'b0 || image_out !== '0) begin
                bad++;
                $display("FAIL reset_no_resume cyc%0d: ready=%b img_zero=%b need 0/1",
                         i, pixel_ready, image_out == '0);
            end
        end
        pixel_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_hold_load();
        test_toggle();
        test_abort();
        test_freeze();
        test_reentry();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
